// File: rtl/vga_fb_arbiter_if.sv
// Frame-buffer arbiter bus: scan-out read, host write, clear control and RAM port.
// Latency: none, wiring only.
// Backpressure: host writes are throttled by wr_ready; scan-out and RAM side have none.
interface vga_fb_arbiter_if #(
  parameter int ADDR_W = 14,
  parameter int DATA_W = 8
);
  // scan-out read path
  logic              disp_req;
  logic [ADDR_W-1:0] disp_addr;
  logic [DATA_W-1:0] disp_data;
  logic              disp_valid;
  // host pixel write
  logic              wr_valid;
  logic [ADDR_W-1:0] wr_addr;
  logic [DATA_W-1:0] wr_data;
  logic              wr_ready;
  // clear-screen engine control/status
  logic              clr_start;
  logic [DATA_W-1:0] clr_color;
  logic              clr_busy;
  logic              clr_done;
  logic              starve_err;
  // single-port RAM
  logic              mem_en;
  logic              mem_we;
  logic [ADDR_W-1:0] mem_addr;
  logic [DATA_W-1:0] mem_wdata;
  logic [DATA_W-1:0] mem_rdata;

  // arbiter side
  modport slave (
    input  disp_req, disp_addr, wr_valid, wr_addr, wr_data, clr_start, clr_color, mem_rdata,
    output disp_data, disp_valid, wr_ready, clr_busy, clr_done, starve_err,
           mem_en, mem_we, mem_addr, mem_wdata
  );

  // users and RAM side
  modport master (
    output disp_req, disp_addr, wr_valid, wr_addr, wr_data, clr_start, clr_color, mem_rdata,
    input  disp_data, disp_valid, wr_ready, clr_busy, clr_done, starve_err,
           mem_en, mem_we, mem_addr, mem_wdata
  );
endinterface

// File: rtl/vga_fb_arbiter.sv
// Shares one single-port frame-buffer RAM between scan-out reads, a clear engine and host writes.
// Latency: scan-out pixel returns RD_LAT+1 cycles after disp_req; grants are combinational.
// Backpressure: scan-out always wins; clear stalls on scan-out; host waits on wr_ready.
module vga_fb_arbiter #(
  parameter int ADDR_W   = 14,
  parameter int DATA_W   = 8,
  parameter int DEPTH    = 16384,
  parameter int RD_LAT   = 1,
  parameter int MAX_WAIT = 1024
) (
  input  logic            clk25mz,
  input  logic            rst_n,
  vga_fb_arbiter_if.slave bus
);

  localparam logic [ADDR_W-1:0] LAST_ADDR = ADDR_W'(DEPTH - 1);
  localparam int                WAIT_W    = $clog2(MAX_WAIT + 1);
  localparam logic [WAIT_W-1:0] WAIT_MAX  = WAIT_W'(MAX_WAIT);
  localparam logic [WAIT_W-1:0] WAIT_LAST = WAIT_W'(MAX_WAIT - 1);

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    CLEAR = 2'd1,
    DONE  = 2'd2
  } state_t;

  state_t            state;
  logic [ADDR_W-1:0] clr_addr;
  logic [DATA_W-1:0] clr_col;
  logic              clr_busy_q;
  logic              clr_done_q;

  logic [RD_LAT-1:0] rd_pipe;
  logic              disp_valid_q;
  logic [DATA_W-1:0] disp_data_q;

  logic [WAIT_W-1:0] wait_cnt;
  logic              starve_q;

  logic              wr_ready_c;
  logic              mem_en_c;
  logic              mem_we_c;
  logic [ADDR_W-1:0] mem_addr_c;
  logic [DATA_W-1:0] mem_wdata_c;
  logic              host_blocked;

  // Host may write only when scan-out is idle this cycle and no fill owns the RAM.
  assign wr_ready_c   = !bus.disp_req && (state == IDLE) && rst_n;
  assign host_blocked = bus.wr_valid && !wr_ready_c;

  // Fixed-priority RAM grant: scan-out, then clear engine, then host.
  always_comb begin
    mem_en_c    = 1'b0;
    mem_we_c    = 1'b0;
    mem_addr_c  = '0;
    mem_wdata_c = '0;
    if (rst_n) begin
      if (bus.disp_req) begin
        mem_en_c   = 1'b1;
        mem_addr_c = bus.disp_addr;
      end else if (state == CLEAR) begin
        mem_en_c    = 1'b1;
        mem_we_c    = 1'b1;
        mem_addr_c  = clr_addr;
        mem_wdata_c = clr_col;
      end else if (bus.wr_valid && (state == IDLE)) begin
        mem_en_c    = 1'b1;
        mem_we_c    = 1'b1;
        mem_addr_c  = bus.wr_addr;
        mem_wdata_c = bus.wr_data;
      end
    end
  end

  // Clear engine: walk every address once, pausing on cycles scan-out owns the RAM.
  always_ff @(posedge clk25mz or negedge rst_n) begin
    if (!rst_n) begin
      state      <= IDLE;
      clr_addr   <= '0;
      clr_col    <= '0;
      clr_busy_q <= 1'b0;
      clr_done_q <= 1'b0;
    end else begin
      case (state)
        IDLE: begin
          clr_done_q <= 1'b0;
          if (bus.clr_start) begin
            state      <= CLEAR;
            clr_addr   <= '0;
            clr_col    <= bus.clr_color;
            clr_busy_q <= 1'b1;
          end
        end
        CLEAR: begin
          if (!bus.disp_req) begin
            if (clr_addr == LAST_ADDR) begin
              state      <= DONE;
              clr_busy_q <= 1'b0;
              clr_done_q <= 1'b1;
            end else begin
              clr_addr <= clr_addr + 1'b1;
            end
          end
        end
        DONE: begin
          state      <= IDLE;
          clr_done_q <= 1'b0;
        end
        default: begin
          state      <= IDLE;
          clr_busy_q <= 1'b0;
          clr_done_q <= 1'b0;
        end
      endcase
    end
  end

  // Track granted reads through the RAM latency and capture the returned pixel.
  always_ff @(posedge clk25mz or negedge rst_n) begin
    if (!rst_n) begin
      rd_pipe      <= '0;
      disp_valid_q <= 1'b0;
      disp_data_q  <= '0;
    end else begin
      rd_pipe      <= (rd_pipe << 1) | RD_LAT'(bus.disp_req);
      disp_valid_q <= rd_pipe[RD_LAT-1];
      if (rd_pipe[RD_LAT-1]) begin
        disp_data_q <= bus.mem_rdata;
      end
    end
  end

  // Count consecutive blocked host cycles; flag starvation once the limit is hit.
  always_ff @(posedge clk25mz or negedge rst_n) begin
    if (!rst_n) begin
      wait_cnt <= '0;
      starve_q <= 1'b0;
    end else if (!host_blocked) begin
      wait_cnt <= '0;
    end else if (wait_cnt != WAIT_MAX) begin
      wait_cnt <= wait_cnt + 1'b1;
      if (wait_cnt == WAIT_LAST) begin
        starve_q <= 1'b1;
      end
    end
  end

  assign bus.wr_ready   = wr_ready_c;
  assign bus.mem_en     = mem_en_c;
  assign bus.mem_we     = mem_we_c;
  assign bus.mem_addr   = mem_addr_c;
  assign bus.mem_wdata  = mem_wdata_c;
  assign bus.disp_valid = disp_valid_q;
  assign bus.disp_data  = disp_data_q;
  assign bus.clr_busy   = clr_busy_q;
  assign bus.clr_done   = clr_done_q;
  assign bus.starve_err = starve_q;

endmodule
